// File: rtl/led_pkg.sv
// Shared definitions for the LED column shift driver: FSM state encoding and column count.
package led_pkg;

  localparam int LED_COLS = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } led_state_t;

endpackage

// File: rtl/led_sclk_div.sv
// Serial-clock phase generator: CLK_DIV cycles low then CLK_DIV cycles high per bit, bit_end on the last high cycle.
// Held in phase 0 (low, count cleared) whenever run is low, so every bit starts with a full low phase.
module led_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic run,
  output logic phase_hi,
  output logic bit_end
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] cnt;
  logic          phase_end;

  assign phase_end = (cnt == PW'(CLK_DIV - 1));
  assign bit_end   = run && phase_hi && phase_end;

  always_ff @(posedge clk) begin
    if (!run) begin
      cnt      <= '0;
      phase_hi <= 1'b0;
    end else if (phase_end) begin
      cnt      <= '0;
      phase_hi <= ~phase_hi;
    end else begin
      cnt      <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/led_shift_driver.sv
// Captures a column pattern CAP_DLY cycles after each toggle edge and shifts it MSB-first into the LED chain, then latches.
// Edges arriving while busy are dropped and flagged on o_overrun; all outputs are registered.
module led_shift_driver
  import led_pkg::*;
#(
  parameter int WIDTH   = LED_COLS,
  parameter int CLK_DIV = 4,
  parameter int CAP_DLY = 10,
  parameter int LATCH_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic [WIDTH-1:0] i_pattern,
  input  logic             i_toggle_sync,
  input  logic             i_head_flag,
  output logic             o_sclk,
  output logic             o_sdata,
  output logic             o_latch,
  output logic             o_oe_n,
  output logic             o_head,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int DW = $clog2(CAP_DLY + 1);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LW = (LATCH_W > 1) ? $clog2(LATCH_W) : 1;

  led_state_t       state, state_nxt;
  logic             tog_q, ena_q, edge_det;
  logic [DW-1:0]    dly, dly_nxt;
  logic [BW-1:0]    bit_idx, bit_nxt;
  logic [LW-1:0]    lat_cnt, lat_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic             head_cap, head_cap_nxt, head_nxt;
  logic             run, sclk_hi, bit_end;

  assign edge_det = i_toggle_sync ^ tog_q;
  assign o_oe_n   = ~ena_q;
  assign o_sclk   = sclk_hi;
  // Reset must also stop the divider so o_sclk is low in the cycle after reset.
  assign run      = (state == SHIFT) && i_ena && !i_rst;

  led_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
    .clk      (i_clk),
    .run      (run),
    .phase_hi (sclk_hi),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_nxt    = state;
    dly_nxt      = dly;
    bit_nxt      = bit_idx;
    lat_nxt      = lat_cnt;
    shift_nxt    = shift_reg;
    head_cap_nxt = head_cap;
    head_nxt     = o_head;
    if (!i_ena) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // ena_q excludes an edge that coincides with enable rising.
          if (edge_det && ena_q) begin
            state_nxt = WAIT;
            dly_nxt   = '0;
          end
        end
        WAIT: begin
          if (dly == DW'(CAP_DLY - 1)) begin
            state_nxt    = SHIFT;
            shift_nxt    = i_pattern;
            head_cap_nxt = i_head_flag;
            bit_nxt      = BW'(WIDTH - 1);
          end else begin
            dly_nxt = dly + DW'(1);
          end
        end
        SHIFT: begin
          if (bit_end) begin
            shift_nxt = shift_reg << 1;
            if (bit_idx == '0) begin
              state_nxt = LATCH;
              lat_nxt   = '0;
              head_nxt  = head_cap;
            end else begin
              bit_nxt = bit_idx - BW'(1);
            end
          end
        end
        LATCH: begin
          if (lat_cnt == LW'(LATCH_W - 1)) state_nxt = IDLE;
          else                             lat_nxt   = lat_cnt + LW'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    tog_q <= i_toggle_sync;
    if (i_rst) begin
      state     <= IDLE;
      ena_q     <= 1'b0;
      dly       <= '0;
      bit_idx   <= '0;
      lat_cnt   <= '0;
      shift_reg <= '0;
      head_cap  <= 1'b0;
      o_sdata   <= 1'b0;
      o_latch   <= 1'b0;
      o_head    <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_nxt;
      ena_q     <= i_ena;
      dly       <= dly_nxt;
      bit_idx   <= bit_nxt;
      lat_cnt   <= lat_nxt;
      shift_reg <= shift_nxt;
      head_cap  <= head_cap_nxt;
      o_sdata   <= (state_nxt == SHIFT) ? shift_nxt[WIDTH-1] : 1'b0;
      o_latch   <= (state_nxt == LATCH);
      o_head    <= head_nxt;
      o_busy    <= (state_nxt != IDLE);
      o_overrun <= i_ena && (o_overrun || (edge_det && state != IDLE));
    end
  end

endmodule
